// File: rtl/cpu_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module  : cpu_ctrl_param
// Brief   : Parametrised phase-stepped CPU control unit with halt/single-step
//           debug and a saturating retired-instruction counter.
// Rev     : 1.0
// ============================================================================
module cpu_ctrl_param #(
    parameter int pDATA_WIDTH   = 8,
    parameter int pNUM_REGS     = 4,
    parameter int pPHASE_CYCLES = 2,
    parameter int pCNT_WIDTH    = 16
) (
    input  logic                           iclk,
    input  logic                           irst_n,
    input  logic                           ien,
    input  logic                           ihalt,
    input  logic                           istep_mode,
    input  logic                           istep,
    input  logic [pDATA_WIDTH-1:0]         idir_data,
    input  logic [3:0]                     ialu_flag,
    output logic [pNUM_REGS+6:0]           oreg_en,
    output logic [$clog2(pNUM_REGS+4)-1:0] odata_sel,
    output logic [2:0]                     oalu_opcode,
    output logic                           oforce_rb,
    output logic                           oflag_clf,
    output logic                           odone,
    output logic                           ohalted,
    output logic [2:0]                     ostate,
    output logic [pCNT_WIDTH-1:0]          oinstr_cnt
);

    localparam int c_RW   = $clog2(pNUM_REGS);
    localparam int c_SELW = $clog2(pNUM_REGS + 4);
    localparam int c_ENW  = pNUM_REGS + 7;
    localparam int c_PHW  = $clog2(pPHASE_CYCLES);
    localparam int c_LO   = (2 * c_RW > 4) ? 2 * c_RW : 4;

    localparam int c_EN_TMP = pNUM_REGS;
    localparam int c_EN_ACC = pNUM_REGS + 1;
    localparam int c_EN_FLG = pNUM_REGS + 2;
    localparam int c_EN_AIR = pNUM_REGS + 3;
    localparam int c_EN_AME = pNUM_REGS + 4;
    localparam int c_EN_DIR = pNUM_REGS + 5;
    localparam int c_EN_DME = pNUM_REGS + 6;

    localparam logic [c_SELW-1:0] c_SEL_ACC = c_SELW'(pNUM_REGS);
    localparam logic [c_SELW-1:0] c_SEL_DME = c_SELW'(pNUM_REGS + 1);
    localparam logic [c_SELW-1:0] c_SEL_AIR = c_SELW'(pNUM_REGS + 2);
    localparam logic [c_SELW-1:0] c_SEL_USR = c_SELW'(pNUM_REGS + 3);

    localparam logic [c_PHW-1:0] c_PH_LAST = c_PHW'(pPHASE_CYCLES - 1);

    localparam logic [3:0] c_OP_LD    = 4'b0000;
    localparam logic [3:0] c_OP_ST    = 4'b0001;
    localparam logic [3:0] c_OP_DATA  = 4'b0010;
    localparam logic [3:0] c_OP_JMPR  = 4'b0011;
    localparam logic [3:0] c_OP_JMP   = 4'b0100;
    localparam logic [3:0] c_OP_JFLAG = 4'b0101;
    localparam logic [3:0] c_OP_CLF   = 4'b0110;
    localparam logic [3:0] c_OP_END   = 4'b1100;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_F1   = 3'd1,
        ST_F2   = 3'd2,
        ST_F3   = 3'd3,
        ST_E1   = 3'd4,
        ST_E2   = 3'd5,
        ST_E3   = 3'd6,
        ST_HALT = 3'd7
    } state_t;

    state_t                  state_q, state_d;
    logic [c_PHW-1:0]        phase_q, phase_d;
    logic                    done_q, done_d;
    logic                    step_pend_q, step_pend_d;
    logic [pCNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [c_ENW-1:0]        reg_en_q, reg_en_d;
    logic [c_SELW-1:0]       data_sel_q, data_sel_d;
    logic                    force_rb_q, force_rb_d;
    logic                    flag_clf_q, flag_clf_d;

    logic [3:0]              w_opc;
    logic [c_RW-1:0]         w_ra;
    logic [c_RW-1:0]         w_rb;
    logic                    w_is_end;
    logic                    w_flag_ok;
    logic                    w_boundary;
    logic                    w_go_f1;
    logic                    w_consume;
    logic                    w_retire;
    logic                    w_unused_dir;

    assign w_opc      = idir_data[pDATA_WIDTH-1 -: 4];
    assign w_ra       = idir_data[2*c_RW-1 -: c_RW];
    assign w_rb       = idir_data[c_RW-1:0];
    assign w_is_end   = (w_opc == c_OP_END) && (&w_ra) && (&w_rb);
    assign w_flag_ok  = &(ialu_flag | ~idir_data[3:0]);
    assign w_boundary = ien && (phase_q == c_PH_LAST);
    // ihalt always wins; in step mode a pending step is required to fetch
    assign w_go_f1    = !ihalt && (!istep_mode || step_pend_q);

    generate
        if (pDATA_WIDTH - 4 > c_LO) begin : g_dir_spare
            assign w_unused_dir = ^idir_data[pDATA_WIDTH-5:c_LO];
        end else begin : g_dir_full
            assign w_unused_dir = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        cnt_d     = cnt_q;
        w_consume = 1'b0;
        w_retire  = 1'b0;
        phase_d   = (phase_q == c_PH_LAST) ? '0 : phase_q + 1'b1;

        if (w_boundary) begin
            case (state_q)
                ST_IDLE: begin
                    if (!done_q) begin
                        state_d   = w_go_f1 ? ST_F1 : ST_HALT;
                        w_consume = w_go_f1;
                    end
                end
                ST_HALT: begin
                    state_d   = w_go_f1 ? ST_F1 : ST_HALT;
                    w_consume = w_go_f1;
                end
                ST_F1: state_d = ST_F2;
                ST_F2: state_d = ST_F3;
                ST_F3: begin
                    state_d = ST_E1;
                    if (w_is_end) begin
                        done_d = 1'b1;
                    end
                end
                ST_E1: begin
                    if (w_is_end) begin
                        state_d  = ST_IDLE;
                        w_retire = 1'b1;
                    end else begin
                        state_d  = ST_E2;
                    end
                end
                ST_E2: state_d = ST_E3;
                ST_E3: begin
                    w_retire  = 1'b1;
                    state_d   = w_go_f1 ? ST_F1 : ST_HALT;
                    w_consume = w_go_f1;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (w_retire && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end

        // A pulse while a step is already pending leaves it at 1, i.e. ignored
        if (w_consume && step_pend_q) begin
            step_pend_d = 1'b0;
        end else if (istep && istep_mode) begin
            step_pend_d = 1'b1;
        end else begin
            step_pend_d = step_pend_q;
        end

        if (!ien) begin
            state_d     = ST_IDLE;
            phase_d     = '0;
            done_d      = 1'b0;
            step_pend_d = 1'b0;
            cnt_d       = '0;
        end
    end

    // Control word for the state being entered; idle word on every other edge
    always_comb begin
        reg_en_d   = '0;
        data_sel_d = c_SEL_USR;
        force_rb_d = 1'b0;
        flag_clf_d = 1'b0;

        if (w_boundary) begin
            case (state_d)
                ST_F1: begin
                    data_sel_d         = c_SEL_AIR;
                    force_rb_d         = 1'b1;
                    reg_en_d[c_EN_ACC] = 1'b1;
                    reg_en_d[c_EN_AME] = 1'b1;
                end
                ST_F2: begin
                    data_sel_d         = c_SEL_DME;
                    reg_en_d[c_EN_DIR] = 1'b1;
                end
                ST_F3: begin
                    data_sel_d         = c_SEL_ACC;
                    reg_en_d[c_EN_AIR] = 1'b1;
                end
                ST_E1: begin
                    if (w_opc[3]) begin
                        if (!w_is_end) begin
                            data_sel_d         = c_SELW'(w_rb);
                            reg_en_d[c_EN_TMP] = 1'b1;
                        end
                    end else begin
                        case (w_opc)
                            c_OP_LD, c_OP_ST: begin
                                data_sel_d         = c_SELW'(w_ra);
                                reg_en_d[c_EN_AME] = 1'b1;
                            end
                            c_OP_DATA, c_OP_JFLAG: begin
                                data_sel_d         = c_SEL_AIR;
                                force_rb_d         = 1'b1;
                                reg_en_d[c_EN_AME] = 1'b1;
                                reg_en_d[c_EN_ACC] = 1'b1;
                            end
                            c_OP_JMPR: begin
                                data_sel_d         = c_SELW'(w_rb);
                                reg_en_d[c_EN_AIR] = 1'b1;
                            end
                            c_OP_JMP: begin
                                data_sel_d         = c_SEL_AIR;
                                reg_en_d[c_EN_AME] = 1'b1;
                            end
                            c_OP_CLF: flag_clf_d = 1'b1;
                            default: ;
                        endcase
                    end
                end
                ST_E2: begin
                    if (w_opc[3]) begin
                        data_sel_d         = c_SELW'(w_ra);
                        reg_en_d[c_EN_ACC] = 1'b1;
                        reg_en_d[c_EN_FLG] = 1'b1;
                    end else begin
                        case (w_opc)
                            c_OP_LD, c_OP_DATA: begin
                                data_sel_d     = c_SEL_DME;
                                reg_en_d[w_rb] = 1'b1;
                            end
                            c_OP_ST: begin
                                data_sel_d         = c_SELW'(w_rb);
                                reg_en_d[c_EN_DME] = 1'b1;
                            end
                            c_OP_JMP: begin
                                data_sel_d         = c_SEL_DME;
                                reg_en_d[c_EN_AIR] = 1'b1;
                            end
                            c_OP_JFLAG: begin
                                data_sel_d         = w_flag_ok ? c_SEL_DME : c_SEL_ACC;
                                reg_en_d[c_EN_AIR] = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_E3: begin
                    if (w_opc[3]) begin
                        // compare only updates flags, no writeback
                        if (w_opc[2:0] != 3'b111) begin
                            data_sel_d     = c_SEL_ACC;
                            reg_en_d[w_rb] = 1'b1;
                        end
                    end else if (w_opc == c_OP_DATA) begin
                        data_sel_d         = c_SEL_ACC;
                        reg_en_d[c_EN_AIR] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            done_q      <= 1'b0;
            step_pend_q <= 1'b0;
            cnt_q       <= '0;
            reg_en_q    <= '0;
            data_sel_q  <= c_SEL_USR;
            force_rb_q  <= 1'b0;
            flag_clf_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            done_q      <= done_d;
            step_pend_q <= step_pend_d;
            cnt_q       <= cnt_d;
            reg_en_q    <= reg_en_d;
            data_sel_q  <= data_sel_d;
            force_rb_q  <= force_rb_d;
            flag_clf_q  <= flag_clf_d;
        end
    end

    assign oreg_en     = reg_en_q;
    assign odata_sel   = data_sel_q;
    assign oforce_rb   = force_rb_q;
    assign oflag_clf   = flag_clf_q;
    assign oalu_opcode = force_rb_q ? 3'd0 : (w_opc[3] ? w_opc[2:0] : 3'd0);
    assign odone       = done_q;
    assign ohalted     = (state_q == ST_HALT);
    assign ostate      = state_q;
    assign oinstr_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_ctrl_param
// Brief   : Scoreboarded directed bench for cpu_ctrl_param (default and 8-reg configs).
// Rev     : 1.0
// ============================================================================
module tb_cpu_ctrl_param;

    localparam logic [2:0] S_IDLE = 3'd0, S_F1 = 3'd1, S_F2 = 3'd2, S_F3 = 3'd3;
    localparam logic [2:0] S_E1 = 3'd4, S_E2 = 3'd5, S_E3 = 3'd6, S_HALT = 3'd7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, en8, halt, step_mode, step;
    logic [7:0]  dir;
    logic [11:0] dir8;
    logic [3:0]  flag;

    logic [10:0] reg_en;
    logic [2:0]  data_sel, alu_opc, state;
    logic        frb, clf, done, halted;
    logic [15:0] cnt;

    logic [14:0] reg_en8;
    logic [3:0]  data_sel8;
    logic [2:0]  alu_opc8, state8;
    logic        frb8, clf8, done8, halted8;
    logic [15:0] cnt8;

    int checks = 0;
    int errors = 0;

    cpu_ctrl_param u_dut (
        .iclk(clk), .irst_n(rst_n), .ien(en), .ihalt(halt), .istep_mode(step_mode),
        .istep(step), .idir_data(dir), .ialu_flag(flag), .oreg_en(reg_en),
        .odata_sel(data_sel), .oalu_opcode(alu_opc), .oforce_rb(frb), .oflag_clf(clf),
        .odone(done), .ohalted(halted), .ostate(state), .oinstr_cnt(cnt)
    );

    cpu_ctrl_param #(.pDATA_WIDTH(12), .pNUM_REGS(8), .pPHASE_CYCLES(4), .pCNT_WIDTH(16)) u_dut8 (
        .iclk(clk), .irst_n(rst_n), .ien(en8), .ihalt(halt), .istep_mode(step_mode),
        .istep(step), .idir_data(dir8), .ialu_flag(flag), .oreg_en(reg_en8),
        .odata_sel(data_sel8), .oalu_opcode(alu_opc8), .oforce_rb(frb8), .oflag_clf(clf8),
        .odone(done8), .ohalted(halted8), .ostate(state8), .oinstr_cnt(cnt8)
    );

    typedef struct {
        logic [2:0]  st;
        logic [10:0] en;
        logic [2:0]  sel;
        logic        frb;
        logic        clf;
        logic [2:0]  opc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic [10:0] e, input logic [2:0] s,
                        input logic f, input logic c, input logic [2:0] o);
        exp_t x;
        x.st = st; x.en = e; x.sel = s; x.frb = f; x.clf = c; x.opc = o;
        sb.push_back(x);
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim);
        int k = 0;
        while (state !== s && k < lim) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Pops each expected control word as the DUT enters the matching state
    task automatic drain();
        exp_t x;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            wait_state(x.st, 64);
            chk("sb_state", state, x.st);
            chk("sb_reg_en", reg_en, x.en);
            chk("sb_data_sel", data_sel, x.sel);
            chk("sb_force_rb", frb, x.frb);
            chk("sb_flag_clf", clf, x.clf);
            chk("sb_alu_opcode", alu_opc, x.opc);
            @(negedge clk);
        end
    endtask

    task automatic instr(input logic [7:0] d, input logic [3:0] f, input logic [2:0] op,
                         input logic [10:0] en1, input logic [2:0] s1, input logic frb1,
                         input logic clf1, input logic [10:0] en2, input logic [2:0] s2,
                         input logic [10:0] en3, input logic [2:0] s3);
        dir  = d;
        flag = f;
        push(S_F1, 11'h120, 3'd6, 1'b1, 1'b0, 3'd0);
        push(S_F2, 11'h200, 3'd5, 1'b0, 1'b0, op);
        push(S_F3, 11'h080, 3'd4, 1'b0, 1'b0, op);
        push(S_E1, en1, s1, frb1, clf1, frb1 ? 3'd0 : op);
        push(S_E2, en2, s2, 1'b0, 1'b0, op);
        push(S_E3, en3, s3, 1'b0, 1'b0, op);
        drain();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int nf;
        int k;
        rst_n = 1'b0; en = 1'b0; en8 = 1'b0; halt = 1'b0; step_mode = 1'b0; step = 1'b0;
        dir = 8'h86; dir8 = 12'h02B; flag = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_state", state, S_IDLE);
        chk("rst_reg_en", reg_en, 0);
        chk("rst_data_sel", data_sel, 7);
        chk("rst_force_rb", frb, 0);
        chk("rst_flag_clf", clf, 0);
        chk("rst_done", done, 0);
        chk("rst_halted", halted, 0);
        chk("rst_cnt", cnt, 0);

        rst_n = 1'b1; en = 1'b1;
        instr(8'h86, 4'h0, 3'd0, 11'h010, 3'd2, 1'b0, 1'b0, 11'h060, 3'd1, 11'h004, 3'd4);
        chk("add_cnt_in_e3", cnt, 0);
        wait_state(S_F1, 8);
        chk("add_next_f1", state, S_F1);
        chk("add_cnt", cnt, 1);

        // Asynchronous reset in the middle of the next instruction's E2
        wait_state(S_E2, 32);
        chk("pre_rst_e2", state, S_E2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", state, S_IDLE);
        chk("arst_reg_en", reg_en, 0);
        chk("arst_data_sel", data_sel, 7);
        chk("arst_cnt", cnt, 0);
        dir = 8'hEC;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); chk("boot_cycle1", state, S_IDLE);
        @(negedge clk); chk("boot_cycle2", state, S_F1);

        instr(8'hEC, 4'h0, 3'd6, 11'h010, 3'd0, 1'b0, 1'b0, 11'h060, 3'd3, 11'h001, 3'd4);
        instr(8'hF6, 4'h0, 3'd7, 11'h010, 3'd2, 1'b0, 1'b0, 11'h060, 3'd1, 11'h000, 3'd7);
        instr(8'h51, 4'h0, 3'd0, 11'h120, 3'd6, 1'b1, 1'b0, 11'h080, 3'd4, 11'h000, 3'd7);
        instr(8'h51, 4'h1, 3'd0, 11'h120, 3'd6, 1'b1, 1'b0, 11'h080, 3'd5, 11'h000, 3'd7);
        instr(8'h53, 4'h1, 3'd0, 11'h120, 3'd6, 1'b1, 1'b0, 11'h080, 3'd4, 11'h000, 3'd7);
        instr(8'h60, 4'h0, 3'd0, 11'h000, 3'd7, 1'b0, 1'b1, 11'h000, 3'd7, 11'h000, 3'd7);
        instr(8'h70, 4'h0, 3'd0, 11'h000, 3'd7, 1'b0, 1'b0, 11'h000, 3'd7, 11'h000, 3'd7);
        instr(8'h22, 4'h0, 3'd0, 11'h120, 3'd6, 1'b1, 1'b0, 11'h004, 3'd5, 11'h080, 3'd4);
        instr(8'h1B, 4'h0, 3'd0, 11'h100, 3'd2, 1'b0, 1'b0, 11'h400, 3'd3, 11'h000, 3'd7);
        instr(8'h40, 4'h0, 3'd0, 11'h100, 3'd6, 1'b0, 1'b0, 11'h080, 3'd5, 11'h000, 3'd7);
        instr(8'h33, 4'h0, 3'd0, 11'h080, 3'd3, 1'b0, 1'b0, 11'h000, 3'd7, 11'h000, 3'd7);
        instr(8'h0E, 4'h0, 3'd0, 11'h100, 3'd3, 1'b0, 1'b0, 11'h004, 3'd5, 11'h000, 3'd7);

        // END: done after E1, back to idle, no further fetch
        dir = 8'hCF; flag = 4'h0;
        push(S_F1, 11'h120, 3'd6, 1'b1, 1'b0, 3'd0);
        push(S_F2, 11'h200, 3'd5, 1'b0, 1'b0, 3'd4);
        push(S_F3, 11'h080, 3'd4, 1'b0, 1'b0, 3'd4);
        push(S_E1, 11'h000, 3'd7, 1'b0, 1'b0, 3'd4);
        drain();
        chk("end_done_in_e1", done, 1);
        wait_state(S_IDLE, 8);
        chk("end_idle", state, S_IDLE);
        chk("end_cnt", cnt, 13);
        nf = 0;
        repeat (20) begin
            @(negedge clk);
            if (state !== S_IDLE) nf++;
        end
        chk("end_no_fetch", nf, 0);
        chk("end_done_sticky", done, 1);
        en = 1'b0;
        @(negedge clk);
        chk("clr_done", done, 0);
        chk("clr_cnt", cnt, 0);
        chk("clr_state", state, S_IDLE);

        // Single-step mode
        dir = 8'h70; step_mode = 1'b1; en = 1'b1;
        repeat (6) @(negedge clk);
        chk("step_halted0", halted, 1);
        step = 1'b1; @(negedge clk); step = 1'b0;
        wait_state(S_F1, 8);
        chk("step1_f1", state, S_F1);
        wait_state(S_HALT, 40);
        chk("step1_halted", halted, 1);
        chk("step1_cnt", cnt, 1);
        step = 1'b1; @(negedge clk); @(negedge clk); step = 1'b0;
        wait_state(S_F1, 8);
        chk("step2_f1", state, S_F1);
        wait_state(S_HALT, 40);
        chk("step2_halted", halted, 1);
        repeat (30) @(negedge clk);
        chk("step2_still_halted", halted, 1);
        chk("step2_cnt", cnt, 2);

        // ihalt overrides a pending step
        halt = 1'b1;
        step = 1'b1; @(negedge clk); step = 1'b0;
        repeat (20) @(negedge clk);
        chk("halt_prio_state", state, S_HALT);
        chk("halt_prio_cnt", cnt, 2);
        halt = 1'b0;
        wait_state(S_F1, 8);
        chk("halt_rel_f1", state, S_F1);
        wait_state(S_HALT, 40);
        chk("halt_rel_halted", halted, 1);
        chk("halt_rel_cnt", cnt, 3);

        // Free run then ihalt at the next instruction boundary
        step_mode = 1'b0;
        wait_state(S_F1, 8);
        chk("free_f1", state, S_F1);
        halt = 1'b1;
        wait_state(S_HALT, 40);
        chk("free_halt", halted, 1);
        halt = 1'b0;
        wait_state(S_F1, 8);
        chk("free_resume", state, S_F1);

        // 8 registers, 12-bit DIR, 4 clocks per step: LD R5 -> R3
        en8 = 1'b1;
        k = 0;
        while (state8 !== S_F1 && k < 40) begin @(negedge clk); k++; end
        chk("c8_f1_state", state8, S_F1);
        chk("c8_f1_reg_en", reg_en8, 15'h1200);
        chk("c8_f1_sel", data_sel8, 10);
        chk("c8_f1_frb", frb8, 1);
        k = 0;
        while (state8 !== S_E1 && k < 40) begin @(negedge clk); k++; end
        chk("c8_e1_state", state8, S_E1);
        chk("c8_e1_reg_en", reg_en8, 15'h1000);
        chk("c8_e1_sel", data_sel8, 5);
        k = 0;
        while (state8 === S_E1 && k < 20) begin
            if (k > 0) begin
                chk("c8_e1_idle_en", reg_en8, 0);
                chk("c8_e1_idle_sel", data_sel8, 11);
            end
            @(negedge clk);
            k++;
        end
        chk("c8_e1_len", k, 4);
        chk("c8_e2_state", state8, S_E2);
        chk("c8_e2_reg_en", reg_en8, 15'h0008);
        chk("c8_e2_sel", data_sel8, 9);
        chk("c8_e2_opc", alu_opc8, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
